// File: rtl/sync_fifo_param_pkg.sv
// Shared defaults and elaboration-time helpers for the parametrised sync FIFO.
package sync_fifo_param_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_AF_LEVEL = 14;
  localparam int unsigned DEF_AE_LEVEL = 2;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  function automatic bit af_level_ok(input int unsigned lvl, input int unsigned addr_w);
    return (lvl >= 32'd1) && (lvl <= (32'd1 << addr_w));
  endfunction

  function automatic bit ae_level_ok(input int unsigned lvl, input int unsigned addr_w);
    return lvl <= ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port storage: synchronous write, registered read with read-enable.
module sync_fifo_param_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array is not reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value on cycles without a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, threshold flags and sticky error flags.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int unsigned PTR_W = ptr_width(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 32'd1;

  if (!af_level_ok(AF_LEVEL, ADDR_W)) begin : g_bad_af_level
    $error("sync_fifo_param: AF_LEVEL must be in 1..2**ADDR_W");
  end
  if (!ae_level_ok(AE_LEVEL, ADDR_W)) begin : g_bad_ae_level
    $error("sync_fifo_param: AE_LEVEL must be in 0..2**ADDR_W-1");
  end

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_we;
  logic w_re;

  // Full when only the wrap bits differ; empty when pointers match exactly.
  assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  // Flush wins over both requests in the same cycle.
  assign w_we = wr && !w_full  && !clear;
  assign w_re = rd && !w_empty && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_we) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_re) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      unique case ({w_we, w_re})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_rd_valid <= w_re;
      if (wr && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  sync_fifo_param_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wptr[ADDR_W-1:0]),
    .i_wdata (data_in),
    .i_re    (w_re),
    .i_raddr (r_rptr[ADDR_W-1:0]),
    .o_rdata (data_out)
  );

  assign rd_valid       = r_rd_valid;
  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign count          = r_count;
  assign almost_full    = (r_count >= CNT_W'(AF_LEVEL));
  assign almost_empty   = (r_count <= CNT_W'(AE_LEVEL));
  assign fifo_overflow  = r_overflow;
  assign fifo_underflow = r_underflow;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the 16x8 fifo_mem.
- Generalised data width and depth.
- Adds fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags with correct semantics, and a registered read port with a data-valid strobe.
- Sits between producer and consumer blocks in the same clock domain; drop-in buffer for the datapath.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush, active high.
- wr  in  1  write request.
- data_in  in  DATA_W  write data, sampled with wr.
- rd  in  1  read request.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  data_out holds the word popped on the previous cycle.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current fill level, 0..DEPTH.
- fifo_overflow  out  1  sticky: a write was attempted while full.
- fifo_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - wptr = rptr = 0, count = 0, data_out = 0.
  - rd_valid = 0, fifo_full = 0, fifo_empty = 1.
  - almost_empty = 1; almost_full = 0.
  - fifo_overflow = 0, fifo_underflow = 0.
- Pointers:
  - wptr and rptr are ADDR_W+1 bits; the MSB is the wrap bit and wraps naturally modulo 2**(ADDR_W+1).
  - Memory is indexed by [ADDR_W-1:0].
- Status flags: full = (wrap bits differ) and (low bits equal); empty = (pointers fully equal). Both are combinational from the registered pointers.
- count: registered; +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. almost_full and almost_empty are combinational from count.
- Accepted write, we = wr & ~fifo_full:
  - Memory is written at wptr on the clock edge; wptr increments.
  - A write while full is always rejected, even with a simultaneous read.
- Accepted read, re = rd & ~fifo_empty:
  - data_out <= mem[rptr] on the edge; rptr increments.
  - rd_valid <= re, so read latency is 1 cycle.
  - A read while empty is always rejected, even with a simultaneous write; no fall-through.
- Non-read cycles: data_out holds its last value when no read is accepted.
- Simultaneous read and write when neither full nor empty: both are accepted; count is unchanged; read and write addresses differ, so no RAM collision.
- fifo_overflow: set on wr & fifo_full; held until clear or reset. Not cleared by a read.
- fifo_underflow: set on rd & fifo_empty; held until clear or reset. Not set by writes.
- clear (synchronous, overrides wr and rd in the same cycle):
  - Pointers, count, rd_valid and both sticky flags go to 0.
  - Memory contents and data_out are not cleared.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any in-flight rd_valid is dropped.

Decomposition:
- Shared package/header fifo_defs holds:
  - the default width/depth constants;
  - the pointer-width function ADDR_W+1;
  - the parameter-legality check macros (AF_LEVEL, AE_LEVEL range).
- One sub-module, fifo_ram: simple dual-port array with synchronous write and registered synchronous read with read-enable.
- Pointer, count, flag and sticky logic stay in the top module.

Test Plan (DATA_W=8, ADDR_W=4, AF_LEVEL=14, AE_LEVEL=2):
- Fill 16 writes 0x00..0x0F: count=16, full=1, almost_full=1 from the 14th write. 17th write (0xAA): rejected, count stays 16, overflow=1 next cycle. Drain 16 reads: data 0x00..0x0F in order, rd_valid high each cycle after rd.
- Read on empty after reset: underflow=1, rd_valid=0, data_out=0, count=0. A subsequent write 0x55 does not clear underflow.
- Wrap-around: 10 writes then 10 reads, repeated 4 times (pointers wrap twice). Data in order, empty=1 and count=0 after each batch.
- Simultaneous rd+wr at count=5: count stays 5. Rd+wr when full: read accepted, write dropped, count=15, overflow=1. Rd+wr when empty: write accepted, read dropped, count=1, underflow=1.
- clear asserted at count=7 with overflow=1 and wr=1 the same cycle: next cycle count=0, empty=1, overflow=0, write not stored.
- rst_n pulsed low mid-burst between clock edges: outputs go to reset values without waiting for a clock edge, and rd_valid=0.
